dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the CPU data port (16-bit word requests) and the data side of the line-oriented memory model.
- Acts as the initiator of the memory's 4-word line fetch/store protocol: drives read/write requests and address, consumes 64-bit fetched lines, and drives 64-bit lines on write-back.

---
 rtl/dcache_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller driving a 4-word line memory.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise both count ports are tied to 0.
module dcache_ctrl #(
   parameter int unsigned NUM_LINES  = 8,
   parameter int unsigned MEM_CYCLES = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        mem_readM,
   output logic        mem_writeM,
   output logic [15:0] mem_address,
   inout  wire  [63:0] mem_data,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = 16 - IDX_W - 2;
   localparam int unsigned CNT_W = 3;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_COMPARE   = 2'd1;
   localparam logic [1:0] S_WRITEBACK = 2'd2;
   localparam logic [1:0] S_ALLOCATE  = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_we;

   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_W-1:0]     tags  [NUM_LINES];
   logic [63:0]          lines [NUM_LINES];

   logic [63:0] wb_line;
   logic        wb_drive;

   logic [1:0]       req_off;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic             hit_c;

   logic        ready_nxt;
   logic [15:0] rdata_nxt;
   logic        read_nxt;
   logic        write_nxt;
   logic [15:0] addr_nxt;
   logic        drive_nxt;
   logic        latch_req;
   logic        do_write;
   logic        do_fill;
   logic        clr_dirty;
   logic        load_wb;

   assign req_off = req_addr[1:0];
   assign req_idx = req_addr[IDX_W+1:2];
   assign req_tag = req_addr[15:IDX_W+2];
   assign hit_c   = valid[req_idx] && (tags[req_idx] == req_tag);

   // Victim line is only driven onto the shared bus during a write-back.
   assign mem_data = wb_drive ? wb_line : {64{1'bz}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         req_addr    <= '0;
         req_wdata   <= '0;
         req_we      <= 1'b0;
         cpu_ready   <= 1'b0;
         cpu_rdata   <= '0;
         mem_readM   <= 1'b0;
         mem_writeM  <= 1'b0;
         mem_address <= '0;
         wb_drive    <= 1'b0;
         wb_line     <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         cpu_ready   <= ready_nxt;
         cpu_rdata   <= rdata_nxt;
         mem_readM   <= read_nxt;
         mem_writeM  <= write_nxt;
         mem_address <= addr_nxt;
         wb_drive    <= drive_nxt;
         if (latch_req) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_we    <= cpu_we;
         end
         if (load_wb) begin
            wb_line <= lines[req_idx];
         end
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      ready_nxt = 1'b0;
      rdata_nxt = cpu_rdata;
      read_nxt  = mem_readM;
      write_nxt = mem_writeM;
      addr_nxt  = mem_address;
      drive_nxt = wb_drive;
      latch_req = 1'b0;
      do_write  = 1'b0;
      do_fill   = 1'b0;
      clr_dirty = 1'b0;
      load_wb   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cpu_req && !cpu_ready) begin
               latch_req = 1'b1;
               state_nxt = S_COMPARE;
               cnt_nxt   = '0;
            end
         end
         S_COMPARE: begin
            cnt_nxt = '0;
            if (hit_c) begin
               if (req_we) begin
                  do_write = 1'b1;
               end else begin
                  rdata_nxt = lines[req_idx][{req_off, 4'b0000} +: 16];
               end
               ready_nxt = 1'b1;
               state_nxt = S_IDLE;
            end else if (valid[req_idx] && dirty[req_idx]) begin
               state_nxt = S_WRITEBACK;
               write_nxt = 1'b1;
               drive_nxt = 1'b1;
               load_wb   = 1'b1;
               addr_nxt  = {tags[req_idx], req_idx, 2'b00};
            end else begin
               state_nxt = S_ALLOCATE;
               read_nxt  = 1'b1;
               addr_nxt  = {req_tag, req_idx, 2'b00};
            end
         end
         S_WRITEBACK: begin
            // Store runs MEM_CYCLES cycles, then one idle bus cycle before the fetch.
            if (cnt == CNT_W'(MEM_CYCLES - 1)) begin
               write_nxt = 1'b0;
               drive_nxt = 1'b0;
               clr_dirty = 1'b1;
            end else if (cnt == CNT_W'(MEM_CYCLES)) begin
               state_nxt = S_ALLOCATE;
               cnt_nxt   = '0;
               read_nxt  = 1'b1;
               addr_nxt  = {req_tag, req_idx, 2'b00};
            end
         end
         S_ALLOCATE: begin
            if (cnt == CNT_W'(MEM_CYCLES - 1)) begin
               do_fill   = 1'b1;
               read_nxt  = 1'b0;
               state_nxt = S_COMPARE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (do_fill) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
         end else if (do_write) begin
            dirty[req_idx] <= 1'b1;
         end else if (clr_dirty) begin
            dirty[req_idx] <= 1'b0;
         end
      end
   end

   // Line data and tags need no reset: valid gates every use.
   always_ff @(posedge clk) begin
      if (do_fill) begin
         lines[req_idx] <= mem_data;
         tags[req_idx]  <= req_tag;
      end else if (do_write) begin
         lines[req_idx][{req_off, 4'b0000} +: 16] <= req_wdata;
      end
   end

`ifdef DCACHE_STATS_EN
   logic first_cmp;

   // Only the first COMPARE of a request is counted; the post-fill COMPARE is not.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_cmp  <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (latch_req) begin
            first_cmp <= 1'b1;
         end else if (state == S_COMPARE) begin
            first_cmp <= 1'b0;
         end
         if ((state == S_COMPARE) && first_cmp) begin
            if (hit_c) begin
               if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
               if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
         end
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl against a flat-memory and tag-table reference model.
// Includes a line memory model that honours the 5-cycle fetch/store protocol and shares reset_n.
module tb_dcache_ctrl;

   localparam int MEM_CYCLES = 5;
   localparam int NUM_LINES  = 8;
   localparam int LAT_HIT    = 2;
   localparam int LAT_CLEAN  = 2 + MEM_CYCLES + 1;
   localparam int LAT_DIRTY  = 2 + 2 * MEM_CYCLES + 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_readM;
   logic        mem_writeM;
   logic [15:0] mem_address;
   wire  [63:0] mem_data;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   dcache_ctrl #(.NUM_LINES(NUM_LINES), .MEM_CYCLES(MEM_CYCLES)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
      .mem_data(mem_data), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Physical memory behind the cache and the CPU-visible reference image.
   logic [15:0] mem     [65536];
   logic [15:0] ref_mem [65536];
   logic [63:0] rd_line;

   assign rd_line = {mem[{mem_address[15:2], 2'd3}], mem[{mem_address[15:2], 2'd2}],
                     mem[{mem_address[15:2], 2'd1}], mem[{mem_address[15:2], 2'd0}]};
   assign mem_data = mem_readM ? rd_line : {64{1'bz}};

   int          wr_run, rd_run, n_fetch, n_wb, last_wr_len, last_rd_len;
   logic [15:0] last_wr_addr, last_rd_addr;
   logic [63:0] last_wr_data;
   logic        both_seen;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_run <= 0;
         rd_run <= 0;
      end else begin
         if (mem_readM && mem_writeM) both_seen <= 1'b1;
         if (mem_writeM) begin
            last_wr_addr <= mem_address;
            if (wr_run == MEM_CYCLES - 1) begin
               for (int k = 0; k < 4; k++) mem[{mem_address[15:2], 2'(k)}] <= mem_data[16*k +: 16];
               last_wr_data <= mem_data;
            end
            wr_run <= wr_run + 1;
         end else begin
            if (wr_run != 0) begin
               last_wr_len <= wr_run;
               n_wb        <= n_wb + 1;
            end
            wr_run <= 0;
         end
         if (mem_readM) begin
            last_rd_addr <= mem_address;
            rd_run       <= rd_run + 1;
         end else begin
            if (rd_run != 0) begin
               last_rd_len <= rd_run;
               n_fetch     <= n_fetch + 1;
            end
            rd_run <= 0;
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: per-index tag table plus expected statistics.
   bit          mvalid [NUM_LINES];
   bit          mdirty [NUM_LINES];
   logic [10:0] mtag   [NUM_LINES];
   int          exp_hits, exp_miss;
   logic [15:0] last_rdata;
   int          last_lat;

   task automatic model_reset();
      for (int i = 0; i < NUM_LINES; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
         mtag[i]   = '0;
      end
      exp_hits = 0;
      exp_miss = 0;
   endtask

   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      int          lat, exp_lat, idx, fetch0, wb0;
      logic        hit, dmiss;
      logic [15:0] vict;
      idx     = int'(addr[4:2]);
      hit     = mvalid[idx] && (mtag[idx] == addr[15:5]);
      dmiss   = !hit && mvalid[idx] && mdirty[idx];
      vict    = {mtag[idx], addr[4:2], 2'b00};
      exp_lat = hit ? LAT_HIT : (dmiss ? LAT_DIRTY : LAT_CLEAN);
      fetch0  = n_fetch;
      wb0     = n_wb;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!cpu_ready && lat < 64);
      last_lat   = lat;
      last_rdata = cpu_rdata;
      check("latency", 64'(lat), 64'(exp_lat));
      if (!we) check("rdata", cpu_rdata, ref_mem[addr]);
      cpu_req = 1'b0;
      if (hit) exp_hits++;
      else     exp_miss++;
      if (!hit) begin
         mvalid[idx] = 1'b1;
         mdirty[idx] = 1'b0;
         mtag[idx]   = addr[15:5];
      end
      if (we) begin
         mdirty[idx]   = 1'b1;
         ref_mem[addr] = wdata;
      end
      @(posedge clk);
      #1;
      check("ready_pulse", cpu_ready, 0);
      check("fetches", 64'(n_fetch - fetch0), 64'(hit ? 0 : 1));
      check("writebacks", 64'(n_wb - wb0), 64'(dmiss ? 1 : 0));
      if (!hit) begin
         check("fetch_addr", last_rd_addr, {addr[15:2], 2'b00});
         check("fetch_len", 64'(last_rd_len), 64'(MEM_CYCLES));
      end
      if (dmiss) begin
         check("wb_addr", last_wr_addr, vict);
         check("wb_len", 64'(last_wr_len), 64'(MEM_CYCLES));
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
      check({tag, "_hits"}, hit_count, 64'(exp_hits));
      check({tag, "_miss"}, miss_count, 64'(exp_miss));
`else
      check({tag, "_hits"}, hit_count, 0);
      check({tag, "_miss"}, miss_count, 0);
`endif
   endtask

   initial begin
      int cyc;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      n_fetch = 0; n_wb = 0; both_seen = 1'b0;
      last_wr_len = 0; last_rd_len = 0;
      last_wr_addr = '0; last_rd_addr = '0; last_wr_data = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h9023; mem[1] = 16'h0001; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
      mem[16'h0023] = 16'h6000;
      for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", cpu_ready, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_readM", mem_readM, 0);
      check("rst_writeM", mem_writeM, 0);
      check("rst_addr", mem_address, 0);
      check_stats("rst");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      access(1'b0, 16'h0002, 16'h0);
      check("tp_rd0002", last_rdata, 16'hFFFF);
      check("tp_lat_clean", 64'(last_lat), 64'(8));
      access(1'b0, 16'h0001, 16'h0);
      check("tp_rd0001", last_rdata, 16'h0001);
      check("tp_lat_hit", 64'(last_lat), 64'(2));
      access(1'b1, 16'h0001, 16'hABCD);
      access(1'b0, 16'h0020, 16'h0);
      check("tp_wb_data", last_wr_data, 64'h0000FFFFABCD9023);
      check("tp_wb_addr", last_wr_addr, 16'h0000);
      access(1'b0, 16'h0023, 16'h0);
      check("tp_rd0023", last_rdata, 16'h6000);
      access(1'b0, 16'h0001, 16'h0);
      check("tp_refetch", last_rdata, 16'hABCD);
      check_stats("tp");

      // Dirty line 0, then abort its write-back with reset in store cycle 3.
      access(1'b1, 16'h0001, 16'h1234);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!mem_writeM && cyc < 20);
      check("wb_start", mem_writeM, 1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b0;
      #1;
      check("abort_writeM", mem_writeM, 0);
      check("abort_readM", mem_readM, 0);
      check("abort_ready", cpu_ready, 0);
      check("abort_addr", mem_address, 0);
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      check("abort_nocommit", mem[1], 16'hABCD);
      for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
      model_reset();
      check_stats("abort");
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      access(1'b0, 16'h0000, 16'h0);
      check("post_rst_miss", 64'(last_lat), 64'(LAT_CLEAN));
      check("post_rst_rd", last_rdata, 16'h9023);

      for (int n = 0; n < 300; n++) begin
         access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 127)), 16'($urandom));
      end
      check_stats("final");
      check("excl_rw", both_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (vectors %0d)", n_vec);
      $fatal(1);
   end

endmodule
